// File: rtl/label_overlay_pkg.sv
// Shared types and constants for the table-driven VGA text-label overlay.
// Descriptor fields are sized for the largest supported geometry; unused upper bits stay zero.
package label_overlay_pkg;

  localparam int GLYPH_LINES = 16;
  localparam int BLANK_CODE  = 0;
  localparam int ROW_W       = 6;
  localparam int DESC_COL_W  = 12;
  localparam int DESC_LEN_W  = 8;

  // Font-ROM glyph codes used by the stock labels
  localparam int CODE_A = 'h02;
  localparam int CODE_H = 'h0c;
  localparam int CODE_O = 'h14;
  localparam int CODE_R = 'h18;

  typedef struct packed {
    logic [ROW_W-1:0]      row;
    logic [DESC_COL_W-1:0] col;
    logic [DESC_LEN_W-1:0] len;
    logic                  blink;
  } label_desc_t;

endpackage

// File: rtl/label_overlay_gen_match.sv
// One label slot: row/column window compare, blink qualification and character index.
module label_match
  import label_overlay_pkg::*;
#(
  parameter int CH_W   = 7,
  parameter int CI_W   = 4,
  parameter int HSCALE = 2
) (
  input  label_desc_t     desc,
  input  logic [CH_W-1:0] qh,
  input  logic [ROW_W-1:0] char_row,
  input  logic            blink_on,
  output logic            match,
  output logic            hidden,
  output logic [CI_W-1:0] char_idx
);

  localparam int EW    = DESC_COL_W + 4;
  localparam int HS_SH = $clog2(HSCALE);

  logic [EW-1:0] qh_ext;
  logic [EW-1:0] col_ext;
  logic [EW-1:0] col_end;

  // Wide enough that col + len*HSCALE never wraps back to column 0
  assign qh_ext  = EW'(qh);
  assign col_ext = EW'(desc.col);
  assign col_end = col_ext + (EW'(desc.len) << HS_SH);

  assign match = (desc.len != '0) && (desc.row == char_row) &&
                 (qh_ext >= col_ext) && (qh_ext < col_end);
  assign hidden   = desc.blink & ~blink_on;
  assign char_idx = CI_W'((qh_ext - col_ext) >> HS_SH);

endmodule

// File: rtl/label_overlay_gen.sv
// Text-label overlay: scan position in, font-ROM row address out, two registered stages.
// Holds a programmable label table, text RAM and a frame-based blink phase.
module label_overlay_gen
  import label_overlay_pkg::*;
#(
  parameter int NUM_LABELS   = 4,
  parameter int MAX_CHARS    = 16,
  parameter int CODE_W       = 5,
  parameter int CH_W         = 7,
  parameter int HSCALE       = 2,
  parameter int VSCALE       = 2,
  parameter int BLINK_FRAMES = 30,
  localparam int IDX_W  = (NUM_LABELS > 1) ? $clog2(NUM_LABELS) : 1,
  localparam int POS_W  = $clog2(MAX_CHARS),
  localparam int LEN_W  = $clog2(MAX_CHARS) + 1,
  localparam int ADDR_W = CODE_W + 4
) (
  input  logic              reloj,
  input  logic              resetM,
  input  logic [CH_W-1:0]   Qh,
  input  logic [9:0]        Qv,
  input  logic              frame_tick,
  input  logic              A_A,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic [5:0]        cfg_row,
  input  logic [CH_W-1:0]   cfg_col,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic              cfg_blink,
  input  logic              txt_we,
  input  logic [IDX_W-1:0]  txt_idx,
  input  logic [POS_W-1:0]  txt_pos,
  input  logic [CODE_W-1:0] txt_code,
  output logic [ADDR_W-1:0] DIR8x16,
  output logic              hit
);

  localparam int VS_SH  = $clog2(VSCALE);
  localparam int ROW_SH = $clog2(GLYPH_LINES * VSCALE);
  localparam int CNT_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [CH_W-1:0]   qh_q, qh_d;
  logic [9:0]        qv_q, qv_d;
  logic              a_a_q, a_a_d;
  label_desc_t       desc_q [NUM_LABELS];
  label_desc_t       desc_d [NUM_LABELS];
  logic [CODE_W-1:0] text_q [NUM_LABELS][MAX_CHARS];
  logic [CODE_W-1:0] text_d [NUM_LABELS][MAX_CHARS];
  logic [CNT_W-1:0]  blink_cnt_q, blink_cnt_d;
  logic              blink_on_q, blink_on_d;
  logic [ADDR_W-1:0] dir_q, dir_d;
  logic              hit_q, hit_d;

  logic [ROW_W-1:0]  char_row;
  logic [3:0]        glyph_line;
  logic [NUM_LABELS-1:0] match_vec;
  logic [NUM_LABELS-1:0] hidden_vec;
  logic [POS_W-1:0]  char_idx_arr [NUM_LABELS];
  logic              found;
  logic [IDX_W-1:0]  win;
  logic [CODE_W-1:0] code;
  logic              blank;

  assign char_row   = ROW_W'(qv_q >> ROW_SH);
  assign glyph_line = 4'(qv_q >> VS_SH);

  for (genvar g = 0; g < NUM_LABELS; g++) begin : g_slot
    label_match #(
      .CH_W   (CH_W),
      .CI_W   (POS_W),
      .HSCALE (HSCALE)
    ) u_match (
      .desc     (desc_q[g]),
      .qh       (qh_q),
      .char_row (char_row),
      .blink_on (blink_on_q),
      .match    (match_vec[g]),
      .hidden   (hidden_vec[g]),
      .char_idx (char_idx_arr[g])
    );
  end

  always_comb begin
    qh_d  = Qh;
    qv_d  = Qv;
    a_a_d = A_A;

    desc_d = desc_q;
    if (cfg_we && (int'(cfg_idx) < NUM_LABELS)) begin
      desc_d[cfg_idx].row   = cfg_row;
      desc_d[cfg_idx].col   = DESC_COL_W'(cfg_col);
      desc_d[cfg_idx].len   = (cfg_len > LEN_W'(MAX_CHARS)) ? DESC_LEN_W'(MAX_CHARS)
                                                            : DESC_LEN_W'(cfg_len);
      desc_d[cfg_idx].blink = cfg_blink;
    end

    text_d = text_q;
    if (txt_we && (int'(txt_idx) < NUM_LABELS)) begin
      text_d[txt_idx][txt_pos] = txt_code;
    end

    blink_cnt_d = blink_cnt_q;
    blink_on_d  = blink_on_q;
    if (frame_tick) begin
      if (blink_cnt_q == CNT_W'(BLINK_FRAMES - 1)) begin
        blink_cnt_d = '0;
        blink_on_d  = ~blink_on_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
  end

  // Lowest-numbered matching slot owns the pixel
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int i = NUM_LABELS - 1; i >= 0; i--) begin
      if (match_vec[i]) begin
        found = 1'b1;
        win   = IDX_W'(i);
      end
    end
    code  = text_q[win][char_idx_arr[win]];
    blank = !found || (code == CODE_W'(BLANK_CODE)) || a_a_q || hidden_vec[win];
    dir_d = blank ? '0 : {code, glyph_line};
    hit_d = !blank;
  end

  always_ff @(posedge reloj) begin
    if (!resetM) begin
      qh_q  <= '0;
      qv_q  <= '0;
      a_a_q <= 1'b0;
      for (int i = 0; i < NUM_LABELS; i++) begin
        desc_q[i] <= '0;
        for (int j = 0; j < MAX_CHARS; j++) begin
          text_q[i][j] <= '0;
        end
      end
      blink_cnt_q <= '0;
      blink_on_q  <= 1'b1;
      dir_q       <= '0;
      hit_q       <= 1'b0;
    end else begin
      qh_q        <= qh_d;
      qv_q        <= qv_d;
      a_a_q       <= a_a_d;
      desc_q      <= desc_d;
      text_q      <= text_d;
      blink_cnt_q <= blink_cnt_d;
      blink_on_q  <= blink_on_d;
      dir_q       <= dir_d;
      hit_q       <= hit_d;
    end
  end

  assign DIR8x16 = dir_q;
  assign hit     = hit_q;

endmodule

// File: tb/tb_label_overlay_gen.sv
// Directed bench for label_overlay_gen: expected {hit, DIR8x16} pushed at issue, checked by a monitor.
module tb_label_overlay_gen;
  import label_overlay_pkg::*;

  localparam int W = 10;

  logic       reloj = 1'b0;
  logic       resetM = 1'b0;
  logic [6:0] Qh = '0;
  logic [9:0] Qv = '0;
  logic       frame_tick = 1'b0;
  logic       A_A = 1'b0;
  logic       cfg_we = 1'b0;
  logic [1:0] cfg_idx = '0;
  logic [5:0] cfg_row = '0;
  logic [6:0] cfg_col = '0;
  logic [4:0] cfg_len = '0;
  logic       cfg_blink = 1'b0;
  logic       txt_we = 1'b0;
  logic [1:0] txt_idx = '0;
  logic [3:0] txt_pos = '0;
  logic [4:0] txt_code = '0;
  logic [8:0] DIR8x16;
  logic       hit;

  always #5 reloj = ~reloj;

  label_overlay_gen #(.BLINK_FRAMES(2)) dut (
    .reloj(reloj), .resetM(resetM), .Qh(Qh), .Qv(Qv), .frame_tick(frame_tick), .A_A(A_A),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_row(cfg_row), .cfg_col(cfg_col),
    .cfg_len(cfg_len), .cfg_blink(cfg_blink), .txt_we(txt_we), .txt_idx(txt_idx),
    .txt_pos(txt_pos), .txt_code(txt_code), .DIR8x16(DIR8x16), .hit(hit)
  );

  // Scoreboard
  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           n_vec = 0;
  int           n_bad = 0;
  logic         drv_valid = 1'b0;
  logic         imm_valid = 1'b0;
  logic         v1 = 1'b0, v2 = 1'b0, i1 = 1'b0;
  logic         end_chk = 1'b0;
  logic         end_done = 1'b0;
  logic [W-1:0] mon_exp;
  string        mon_name;

  // Scan samples take two edges to reach the outputs; immediate checks take one
  always @(posedge reloj) begin
    v1 <= drv_valid;
    v2 <= v1;
    i1 <= imm_valid;
  end

  always @(negedge reloj) begin
    if (v2 || i1) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected: got hit=%0b dir=0x%0h with nothing expected", hit, DIR8x16);
      end else begin
        mon_exp  = exp_q.pop_front();
        mon_name = name_q.pop_front();
        if ({hit, DIR8x16} !== mon_exp) begin
          n_bad++;
          $display("FAIL %s: got hit=%0b dir=0x%0h, expected hit=%0b dir=0x%0h",
                   mon_name, hit, DIR8x16, mon_exp[9], mon_exp[8:0]);
        end
      end
    end
    if (end_chk && !end_done) begin
      n_vec++;
      if (exp_q.size() != 0) begin
        n_bad++;
        $display("FAIL drain: got %0d pending entries, expected 0", exp_q.size());
      end
      end_done = 1'b1;
    end
  end

  // Driver tasks: all start and end 1ns after a rising edge
  task automatic drive(input logic [6:0] qh, input logic [9:0] qv,
                       input logic h, input logic [8:0] d, input string nm);
    Qh = qh;
    Qv = qv;
    drv_valid = 1'b1;
    exp_q.push_back({h, d});
    name_q.push_back(nm);
    @(posedge reloj); #1;
  endtask

  task automatic idle(input int n);
    drv_valid = 1'b0;
    repeat (n) begin
      @(posedge reloj); #1;
    end
  endtask

  task automatic check_now(input logic h, input logic [8:0] d, input string nm);
    drv_valid = 1'b0;
    imm_valid = 1'b1;
    exp_q.push_back({h, d});
    name_q.push_back(nm);
    @(posedge reloj); #1;
    imm_valid = 1'b0;
  endtask

  task automatic set_cfg(input logic [1:0] idx, input logic [5:0] row, input logic [6:0] col,
                         input logic [4:0] len, input logic blink);
    cfg_we = 1'b1; cfg_idx = idx; cfg_row = row; cfg_col = col; cfg_len = len; cfg_blink = blink;
  endtask

  task automatic set_txt(input logic [1:0] idx, input logic [3:0] pos, input logic [4:0] code);
    txt_we = 1'b1; txt_idx = idx; txt_pos = pos; txt_code = code;
  endtask

  task automatic commit();
    drv_valid = 1'b0;
    @(posedge reloj); #1;
    cfg_we = 1'b0;
    txt_we = 1'b0;
  endtask

  task automatic tick();
    drv_valid = 1'b0;
    frame_tick = 1'b1;
    @(posedge reloj); #1;
    frame_tick = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge reloj);
    #1;
    check_now(1'b0, 9'h000, "reset_state");
    resetM = 1'b1;
    idle(2);

    // Empty table: blank everywhere
    for (int v = 0; v < 32; v++) begin
      for (int h = 0; h < 128; h++) begin
        drive(7'(h), 10'(v * 32 + v), 1'b0, 9'h000, "sweep_empty");
      end
    end
    idle(3);

    // Label 0 "HORA" at row 5, col 14; descriptor and first char in one cycle
    set_cfg(2'd0, 6'd5, 7'd14, 5'd4, 1'b0);
    set_txt(2'd0, 4'd0, 5'(CODE_H));
    commit();
    set_txt(2'd0, 4'd1, 5'(CODE_O)); commit();
    set_txt(2'd0, 4'd2, 5'(CODE_R)); commit();
    set_txt(2'd0, 4'd3, 5'(CODE_A)); commit();
    drive(7'd21, 10'd162, 1'b1, 9'h021, "write_to_read");
    drive(7'd16, 10'd162, 1'b1, 9'h141, "lbl0_char1");
    drive(7'd14, 10'd162, 1'b1, 9'h0c1, "lbl0_first_col");
    drive(7'd22, 10'd162, 1'b0, 9'h000, "lbl0_past_end");
    drive(7'd13, 10'd162, 1'b0, 9'h000, "lbl0_before_col");
    drive(7'd18, 10'd191, 1'b1, 9'h18f, "lbl0_last_line");
    drive(7'd18, 10'd192, 1'b0, 9'h000, "lbl0_next_row");
    idle(3);

    // Label 1 overlaps label 0 at columns 20-21
    set_cfg(2'd1, 6'd5, 7'd20, 5'd3, 1'b0);
    set_txt(2'd1, 4'd0, 5'h07);
    commit();
    set_txt(2'd1, 4'd1, 5'h09); commit();
    drive(7'd20, 10'd162, 1'b1, 9'h021, "overlap_prio");
    drive(7'd21, 10'd162, 1'b1, 9'h021, "overlap_prio2");
    drive(7'd22, 10'd162, 1'b1, 9'h091, "lbl1_char1");
    drive(7'd24, 10'd162, 1'b0, 9'h000, "blank_code");
    drive(7'd26, 10'd162, 1'b0, 9'h000, "lbl1_past_end");
    idle(3);
    set_cfg(2'd0, 6'd5, 7'd14, 5'd0, 1'b0);
    commit();
    drive(7'd20, 10'd162, 1'b1, 9'h071, "lbl0_disabled");
    drive(7'd16, 10'd162, 1'b0, 9'h000, "lbl0_gone");
    idle(3);

    // Length clamp: 31 becomes 16 characters
    set_cfg(2'd2, 6'd7, 7'd0, 5'd31, 1'b0);
    set_txt(2'd2, 4'd15, 5'h1f);
    commit();
    set_txt(2'd2, 4'd0, 5'h03); commit();
    drive(7'd0,  10'd224, 1'b1, 9'h030, "clamp_first");
    drive(7'd30, 10'd224, 1'b1, 9'h1f0, "clamp_last");
    drive(7'd31, 10'd224, 1'b1, 9'h1f0, "clamp_last2");
    drive(7'd32, 10'd224, 1'b0, 9'h000, "clamp_beyond");
    idle(3);

    // Blinking label 3 next to steady label 2
    set_cfg(2'd3, 6'd8, 7'd40, 5'd2, 1'b1);
    set_txt(2'd3, 4'd0, 5'h11);
    commit();
    drive(7'd40, 10'd256, 1'b1, 9'h110, "blink_init");
    idle(3);
    tick();
    drive(7'd40, 10'd256, 1'b1, 9'h110, "blink_one_tick");
    idle(3);
    tick();
    drive(7'd40, 10'd256, 1'b0, 9'h000, "blink_hidden");
    drive(7'd0,  10'd224, 1'b1, 9'h030, "steady_while_hidden");
    idle(3);
    tick();
    tick();
    drive(7'd40, 10'd256, 1'b1, 9'h110, "blink_visible");
    drive(7'd0,  10'd224, 1'b1, 9'h030, "steady_after");
    idle(3);

    // Global hide
    A_A = 1'b1;
    drive(7'd40, 10'd256, 1'b0, 9'h000, "hide_lbl3");
    drive(7'd0,  10'd224, 1'b0, 9'h000, "hide_lbl2");
    A_A = 1'b0;
    drive(7'd40, 10'd256, 1'b1, 9'h110, "unhide");
    idle(3);

    // Label at the right edge must not wrap into column 0
    set_cfg(2'd1, 6'd9, 7'd126, 5'd4, 1'b0);
    set_txt(2'd1, 4'd0, 5'h05);
    commit();
    drive(7'd126, 10'd288, 1'b1, 9'h050, "edge_col126");
    drive(7'd127, 10'd288, 1'b1, 9'h050, "edge_col127");
    for (int h = 0; h < 6; h++) begin
      drive(7'(h), 10'd288, 1'b0, 9'h000, "no_wrap");
    end
    idle(3);

    // Reset mid-line while a glyph is being drawn
    drive(7'd40, 10'd256, 1'b1, 9'h110, "pre_reset_pipe");
    idle(3);
    check_now(1'b1, 9'h110, "pre_reset_hit");
    resetM = 1'b0;
    check_now(1'b0, 9'h000, "reset_mid_line");
    idle(2);
    resetM = 1'b1;
    idle(2);
    drive(7'd40, 10'd256, 1'b0, 9'h000, "post_reset_lbl3");
    drive(7'd0,  10'd224, 1'b0, 9'h000, "post_reset_lbl2");
    drive(7'd126, 10'd288, 1'b0, 9'h000, "post_reset_lbl1");
    for (int v = 0; v < 10; v++) begin
      for (int h = 0; h < 128; h++) begin
        drive(7'(h), 10'(v * 32 + 3), 1'b0, 9'h000, "post_reset_sweep");
      end
    end
    idle(4);

    end_chk = 1'b1;
    for (int k = 0; k < 20 && !end_done; k++) begin
      @(posedge reloj); #1;
    end
    if (!end_done) begin
      $display("FAIL end_check: monitor did not complete");
      $fatal(1, "end check");
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
